// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared definitions for the sequenced CLA controller: the
//               controller state encoding and the adder slice width.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

  // Width of the shared carry-look-ahead adder slice
  localparam int SLICE_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/adder_4bit_cla.sv
`default_nettype none
// ============================================================================
// Module      : adder_4bit_cla
// Description : 4-bit carry-look-ahead adder slice. Every internal carry is
//               built directly from the generate/propagate terms and the
//               carry-in, so there is no ripple chain inside the slice.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_4bit_cla (
  output logic [3:0] sum,
  output logic       Cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened look-ahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    Cout = c[4];
  end

endmodule : adder_4bit_cla
`default_nettype wire

// File: rtl/cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cla_seq_ctrl
// Description : WIDTH-bit add/subtract through one shared 4-bit CLA slice.
//               One nibble is processed per cycle, LSB first, and the slice
//               carry-out is chained into the next nibble. Valid/ready
//               handshakes on both the operand and the result side.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_seq_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;    // already inverted for subtract
  logic [WIDTH-1:0]   res_q,   res_d;  // partial result being assembled
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               cout_q,  cout_d;
  logic               ovf_q,   ovf_d;
  logic               zero_q,  zero_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   res_next;

  // Select the current nibble of each latched operand for the shared slice
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == i[IDX_W-1:0]) begin
        slice_a = a_q[i*SLICE_W +: SLICE_W];
        slice_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  adder_4bit_cla u_slice (
    .sum  (slice_sum),
    .Cout (slice_cout),
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q)
  );

  // Partial result with the current slice output merged into its nibble
  always_comb begin
    res_next = res_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == i[IDX_W-1:0]) begin
        res_next[i*SLICE_W +: SLICE_W] = slice_sum;
      end
    end
  end

  // Next-state logic: accept, sequence the slices, publish, hand off
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_next;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          // Index is held here; it only restarts from the next accept
          state_d = DONE;
          sum_d   = res_next;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] ~^ b_q[WIDTH-1])
                  & (res_next[WIDTH-1] ^ a_q[WIDTH-1]);
          zero_d  = ~|res_next;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule : cla_seq_ctrl
`default_nettype wire
